shift_auto_stepper: RTL and testbench
=====================================

SHIFT_AUTO_STEPPER -- requirements
Module: shift_auto_stepper

Interface
REQ-001 Parameter N, default 3, shift-amount width.
REQ-002 Parameter Width, default 2**N, operand width.
REQ-003 Parameter TICK_DIV, default 50_000_000, clk cycles per step; legal range >= 2.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sw  input  Width  operand source, captured on load.
REQ-007 load  input  1  load button, level; debounced and clk-synchronous externally.
REQ-008 start_stop  input  1  run/pause button, level; debounced and clk-synchronous externally.
REQ-009 mode  input  2  direction mode: 00 fixed left, 01 fixed right, 10 ping-pong, 11 treated as 10.
REQ-010 a  output  Width  registered operand to the barrel shifter.
REQ-011 amt  output  N  registered shift amount to the barrel shifter.
REQ-012 select  output  1  registered direction: 1 = right, 0 = left.
REQ-013 running  output  1  high while state is RUN.
REQ-014 tick  output  1  one-cycle step strobe.

Function
REQ-015 Rising-edge detection on load and start_stop: edge = in & ~prev; prev registered every cycle.
REQ-016 FSM states IDLE, PAUSE, RUN; IDLE is the only reset state.
REQ-017 Load edge in any state: a <= sw, amt <= 0, prescaler <= 0; IDLE -> PAUSE, RUN and PAUSE unchanged.
REQ-018 A start_stop edge in IDLE is ignored.
REQ-019 A start_stop edge toggles between PAUSE and RUN.
REQ-020 Simultaneous load and start_stop edges: load action only, start_stop edge discarded.
REQ-021 Outputs a, amt and select update on the clock edge at which the triggering edge is sampled and are visible one cycle after the button is first sampled high.
REQ-022 Prescaler width $clog2(TICK_DIV), counts 0..TICK_DIV-1 only in RUN, wraps to 0, holds value in PAUSE and IDLE.
REQ-023 tick is combinationally high exactly when state is RUN and prescaler == TICK_DIV-1; tick is never high outside RUN.
REQ-024 On tick: amt <= (amt + 1) mod Width; amt wraps from Width-1 to 0.
REQ-025 Ping-pong mode: a tick with amt == Width-1 also toggles select.
REQ-026 Fixed modes: select <= mode[0] every cycle regardless of state.
REQ-027 Switching into ping-pong continues from the current select value.
REQ-028 A load edge coinciding with tick takes priority: amt <= 0, no select toggle.
REQ-029 A start_stop edge (RUN -> PAUSE) coinciding with tick: the step still applies in that cycle.
REQ-030 a is changed only by load.

Reset
REQ-031 reset has priority over all inputs.
REQ-032 Reset values: a = 0, amt = 0, select = 0, running = 0, tick = 0, prescaler = 0, state IDLE.
REQ-033 Edge-detect prev registers reset to 1, so a button held through reset generates no edge.
REQ-034 Reset asserted mid-RUN returns every output to its reset value on the next clock edge.

Structure
REQ-035 Package shift_pkg holds the state enum (IDLE, PAUSE, RUN) and the mode encodings (MODE_LEFT, MODE_RIGHT, MODE_PINGPONG).
REQ-036 One sub-module, edge_detect, instanced twice, owns the prev register and edge output.
REQ-037 Outputs a, amt and select connect directly to the barrel shifter's a, amt and select ports; no combinational path from the button inputs to these outputs.

Verification
REQ-038 Bench runs with N=3 and TICK_DIV=4 and covers scenarios REQ-039 to REQ-043.
REQ-039 Reset, then load pulse with sw=8'hA5 -> a=8'hA5, amt=0, state PAUSE, running=0, tick never asserted.
REQ-040 mode=01, start_stop pulse, run 32 cycles -> tick every 4th cycle, amt steps 0..7 then wraps to 0, select=1 throughout.
REQ-041 mode=10, run from amt=0, select=0 for 64 cycles -> select toggles exactly at the amt 7 -> 0 steps, i.e. at tick 8 and tick 16.
REQ-042 load and start_stop rising in the same cycle while PAUSE with sw=8'h3C -> a=8'h3C, amt=0, still PAUSE; and load coincident with tick -> amt=0, no select toggle.
REQ-043 Pause mid-count with prescaler=2, wait 10 cycles, resume -> first tick 1 cycle after resume, amt unchanged while paused.
REQ-044 reset asserted in RUN with amt=5, start_stop held high across reset release -> all outputs 0, state IDLE, no spurious edge.

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_pkg : shared state and direction-mode encodings for the        |
// |             shift auto stepper.                                      |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAUSE = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic [1:0] MODE_LEFT     = 2'b00;
  localparam logic [1:0] MODE_RIGHT    = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

endpackage
`default_nettype wire

// File: rtl/shift_auto_stepper_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_detect : rising-edge detector for a clk-synchronous button.     |
// |               History resets high so a held button is not an edge.  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic edge_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= in_i;
  end

  assign edge_o = in_i & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/shift_auto_stepper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_auto_stepper : steps a barrel shifter's shift amount at a      |
// |                      prescaled rate, with load and run/pause keys.   |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module shift_auto_stepper
  import shift_pkg::*;
#(
  parameter int N        = 3,
  parameter int Width    = 2**N,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] sw,
  input  logic             load,
  input  logic             start_stop,
  input  logic [1:0]       mode,
  output logic [Width-1:0] a,
  output logic [N-1:0]     amt,
  output logic             select,
  output logic             running,
  output logic             tick
);

  localparam int PW = $clog2(TICK_DIV);

  state_e           state_q, state_d;
  logic [Width-1:0] a_q, a_d;
  logic [N-1:0]     amt_q, amt_d;
  logic             select_q, select_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             load_edge, ss_edge, amt_at_top;

  edge_detect u_load_edge (
    .clk    (clk),
    .reset  (reset),
    .in_i   (load),
    .edge_o (load_edge)
  );

  edge_detect u_ss_edge (
    .clk    (clk),
    .reset  (reset),
    .in_i   (start_stop),
    .edge_o (ss_edge)
  );

  assign running    = (state_q == RUN);
  assign tick       = running && (presc_q == PW'(TICK_DIV - 1));
  assign amt_at_top = (amt_q == N'(Width - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    amt_d    = amt_q;
    select_d = select_q;
    presc_d  = presc_q;

    // A load edge swallows any coincident start_stop edge and tick step.
    if (load_edge) begin
      a_d     = sw;
      amt_d   = '0;
      presc_d = '0;
      if (state_q == IDLE) state_d = PAUSE;
    end else begin
      if (running) presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick)    amt_d   = amt_at_top ? '0 : amt_q + 1'b1;
      if (ss_edge) begin
        case (state_q)
          PAUSE:   state_d = RUN;
          RUN:     state_d = PAUSE;
          default: state_d = state_q;
        endcase
      end
    end

    case (mode)
      MODE_LEFT:  select_d = 1'b0;
      MODE_RIGHT: select_d = 1'b1;
      default: begin
        if (!load_edge && tick && amt_at_top) select_d = ~select_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      amt_q    <= '0;
      select_q <= 1'b0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      amt_q    <= amt_d;
      select_q <= select_d;
      presc_q  <= presc_d;
    end
  end

  assign a      = a_q;
  assign amt    = amt_q;
  assign select = select_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_auto_stepper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_shift_auto_stepper : vector table, directed sequences and random  |
// |                         stimulus against a cycle reference model.    |
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
module tb_shift_auto_stepper;

  localparam int W  = 8;
  localparam int TD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1, ld = 1'b0, ss = 1'b0;
  logic [1:0]   md = 2'b00;
  logic [W-1:0] sw_v = '0;
  logic [W-1:0] a;
  logic [2:0]   amt;
  logic         select, running, tick;

  int n_chk = 0;
  int n_err = 0;

  shift_auto_stepper #(.N(3), .Width(W), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(rst), .sw(sw_v), .load(ld), .start_stop(ss), .mode(md),
    .a(a), .amt(amt), .select(select), .running(running), .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 paused, 2 running; cnt is cycles run since the last step.
  int           m_state = 0;
  logic [W-1:0] m_a = '0;
  int           m_amt = 0, m_cnt = 0;
  logic         m_sel = 1'b0, m_pl = 1'b1, m_ps = 1'b1;

  function automatic bit m_tick();
    return (m_state == 2) && (m_cnt == TD - 1);
  endfunction

  task automatic model_clock();
    bit t, le, se;
    t = m_tick();
    if (rst) begin
      m_state = 0; m_a = '0; m_amt = 0; m_sel = 1'b0; m_cnt = 0;
      m_pl = 1'b1; m_ps = 1'b1;
      return;
    end
    le = ld && !m_pl;
    se = ss && !m_ps;
    m_pl = ld;
    m_ps = ss;
    if (le) begin
      m_a = sw_v; m_amt = 0; m_cnt = 0;
      if (m_state == 0) m_state = 1;
    end else begin
      if (t) begin
        if (md[1] && m_amt == W - 1) m_sel = !m_sel;
        m_amt = (m_amt + 1) % W;
      end
      if (m_state == 2) m_cnt = (m_cnt + 1) % TD;
      if (se && m_state != 0) m_state = 3 - m_state;
    end
    if (!md[1]) m_sel = md[0];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    chk("model_a", 32'(a), 32'(m_a));
    chk("model_amt", 32'(amt), 32'(m_amt));
    chk("model_select", 32'(select), 32'(m_sel));
    chk("model_running", 32'(running), 32'(m_state == 2));
    chk("model_tick", 32'(tick), 32'(m_tick()));
  endtask

  task automatic pulse_ld(input logic [W-1:0] v);
    sw_v = v; ld = 1'b1; step(); ld = 1'b0; step();
  endtask

  task automatic pulse_ss();
    ss = 1'b1; step(); ss = 1'b0; step();
  endtask

  typedef struct {
    logic rs, l, s; logic [1:0] m; logic [W-1:0] sv;
    logic [W-1:0] ea; logic [2:0] eamt; logic esel, erun, etick;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  initial begin
    int ticks, bad_sel, max_amt, toggles, t1, t2;
    logic sel_prev, was_tick;
    logic [2:0] amt_p;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'b00, 8'hA5, 8'hA5, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 8'hA5, 8'hA5, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'b00, 8'hFF, 8'hA5, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 2'b00, 8'h3C, 8'h3C, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h3C, 8'h3C, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 2'b00, 8'h3C, 8'h3C, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 2'b00, 8'h3C, 8'h3C, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h3C, 8'h3C, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h3C, 8'h3C, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h3C, 8'h3C, 3'd1, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 2'b01, 8'h3C, 8'h3C, 3'd1, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 2'b01, 8'h3C, 8'h3C, 3'd1, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 2'b01, 8'h3C, 8'h3C, 3'd1, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rs; ld = tbl[i].l; ss = tbl[i].s; md = tbl[i].m; sw_v = tbl[i].sv;
      step();
      chk($sformatf("vec%0d_a", i), 32'(a), 32'(tbl[i].ea));
      chk($sformatf("vec%0d_amt", i), 32'(amt), 32'(tbl[i].eamt));
      chk($sformatf("vec%0d_select", i), 32'(select), 32'(tbl[i].esel));
      chk($sformatf("vec%0d_running", i), 32'(running), 32'(tbl[i].erun));
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(tbl[i].etick));
    end

    // Fixed right: 32 running cycles give 8 ticks and a full 0..7 wrap.
    md = 2'b01;
    pulse_ld(8'h11);
    ss = 1'b1; step(); ss = 1'b0;
    ticks = 0; bad_sel = 0; max_amt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (tick) ticks++;
      if (select !== 1'b1) bad_sel++;
      if (int'(amt) > max_amt) max_amt = int'(amt);
    end
    chk("right_tick_count", 32'(ticks), 32'd8);
    chk("right_select_low", 32'(bad_sel), 32'd0);
    chk("right_amt_max", 32'(max_amt), 32'd7);
    chk("right_amt_wrapped", 32'(amt), 32'd0);
    pulse_ss();
    chk("right_paused", 32'(running), 32'd0);

    // Ping-pong from amt=0, select=0: toggles at the 8th and 16th step.
    md = 2'b00; step();
    md = 2'b10;
    pulse_ld(8'h5A);
    ss = 1'b1; step(); ss = 1'b0;
    ticks = 0; toggles = 0; t1 = -1; t2 = -1; sel_prev = select;
    for (int i = 0; i < 64; i++) begin
      was_tick = tick;
      step();
      if (was_tick) ticks++;
      if (select !== sel_prev) begin
        toggles++;
        if (toggles == 1) t1 = ticks; else if (toggles == 2) t2 = ticks;
      end
      sel_prev = select;
    end
    chk("pp_toggles", 32'(toggles), 32'd2);
    chk("pp_first_toggle_tick", 32'(t1), 32'd8);
    chk("pp_second_toggle_tick", 32'(t2), 32'd16);

    // Load coincident with the wrapping tick: amt clears, select holds.
    for (int i = 0; i < 100 && !(tick === 1'b1 && amt === 3'd7); i++) step();
    chk("wait_tick_amt7", 32'(tick && amt == 3'd7), 32'd1);
    sel_prev = select;
    sw_v = 8'hC3; ld = 1'b1; step(); ld = 1'b0;
    chk("ldtick_amt", 32'(amt), 32'd0);
    chk("ldtick_select", 32'(select), 32'(sel_prev));
    chk("ldtick_running", 32'(running), 32'd1);
    step();

    // Pause with the prescaler at 2, hold 10 cycles, resume: tick right away.
    for (int i = 0; i < 20 && !(m_state == 2 && m_cnt == 2); i++) step();
    chk("wait_presc2", 32'(m_state == 2 && m_cnt == 2), 32'd1);
    ss = 1'b1; step(); ss = 1'b0;
    amt_p = amt; bad_sel = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (amt !== amt_p || tick !== 1'b0) bad_sel++;
    end
    chk("pause_frozen", 32'(bad_sel), 32'd0);
    ss = 1'b1; step(); ss = 1'b0;
    chk("resume_tick", 32'(tick), 32'd1);
    step();
    chk("resume_step", 32'(amt), 32'(3'(amt_p + 3'd1)));

    // Random stimulus, model checked every cycle.
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 49) == 0);
      ld   = ($urandom_range(0, 11) == 0);
      ss   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
      sw_v = 8'($urandom);
      step();
    end

    // Reset mid-run with start_stop held across release.
    rst = 1'b0; ld = 1'b0; ss = 1'b0; md = 2'b01;
    step(); step();
    pulse_ld(8'h99);
    pulse_ss();
    for (int i = 0; i < 100 && amt !== 3'd5; i++) step();
    chk("wait_amt5", 32'(amt), 32'd5);
    rst = 1'b1; ss = 1'b1; step();
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_amt", 32'(amt), 32'd0);
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    rst = 1'b0; step();
    chk("held_ss_no_edge", 32'(running), 32'd0);
    step();
    chk("held_ss_still_idle", 32'(running), 32'd0);
    ss = 1'b0; step();
    ss = 1'b1; step();
    chk("idle_ss_ignored", 32'(running), 32'd0);
    chk("idle_a", 32'(a), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
